// File: rtl/clock_time_ctrl_if.sv
// Handshake bundle between the HH:MM:SS datapath and clock_time_ctrl.
// master = datapath/stimulus side, slave = the controller.
interface clock_time_ctrl_if;
    logic       tick_1hz;
    logic       tick_fast;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic [7:0] hr_q;
    logic       sec_ena;
    logic       sec_clr;
    logic       min_ena;
    logic       hr_ena;
    logic       hr_clr;
    logic [1:0] field_sel;
    logic       blink;

    modport master (
        output tick_1hz, tick_fast, mode_btn, inc_btn, sec_q, min_q, hr_q,
        input  sec_ena, sec_clr, min_ena, hr_ena, hr_clr, field_sel, blink
    );

    modport slave (
        input  tick_1hz, tick_fast, mode_btn, inc_btn, sec_q, min_q, hr_q,
        output sec_ena, sec_clr, min_ena, hr_ena, hr_clr, field_sel, blink
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Timekeeping cascade and button-driven set-mode FSM for the HH:MM:SS clock.
// Optional macro CLOCK_TIME_CTRL_AUTO_REPEAT_EN adds hold-to-repeat on inc in SET_HR/SET_MIN.
module clock_time_ctrl #(
    parameter logic [7:0] HR_MAX     = 8'h23,
    parameter int         TIMEOUT_S  = 30,
    parameter int         HOLD_TICKS = 6
) (
    input  logic              clk,
    input  logic              reset,
    clock_time_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_e;

    localparam logic [7:0] TO_MAX = 8'(TIMEOUT_S);

    state_e     state_q, state_d;
    logic       mode_d_q, inc_d_q;
    logic [7:0] to_q, to_d;
    logic [1:0] fast_q, fast_d;
    logic       phase_q, phase_d;
    logic       sec_ena_q, sec_ena_d, sec_clr_q, sec_clr_d, min_ena_q, min_ena_d;
    logic       hr_ena_q, hr_ena_d, hr_clr_q, hr_clr_d;
    logic       mode_edge, inc_edge, rep, inc_act;

    assign mode_edge = bus.mode_btn & ~mode_d_q;
    assign inc_edge  = bus.inc_btn  & ~inc_d_q;
    assign inc_act   = inc_edge | rep;

`ifdef CLOCK_TIME_CTRL_AUTO_REPEAT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    logic [7:0] hold_q, hold_d;
    logic       holding;

    assign holding = bus.inc_btn && !mode_edge && (state_q == SET_HR || state_q == SET_MIN);

    // Counter saturates at HOLD_LAST; from then on every tick_fast is a repeat.
    always_comb begin
        hold_d = hold_q;
        rep    = 1'b0;
        if (!holding)
            hold_d = '0;
        else if (bus.tick_fast) begin
            if (hold_q >= HOLD_LAST) rep = 1'b1;
            else                     hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    logic unused_hold;
    assign unused_hold = (HOLD_TICKS != 0);
    assign rep         = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        fast_d    = fast_q;
        phase_d   = phase_q;
        sec_ena_d = 1'b0;
        sec_clr_d = 1'b0;
        min_ena_d = 1'b0;
        hr_ena_d  = 1'b0;
        hr_clr_d  = 1'b0;

        if (state_q == RUN) begin
            to_d    = '0;
            fast_d  = '0;
            phase_d = 1'b0;
            if (mode_edge) state_d = SET_HR;
            if (bus.tick_1hz) begin
                sec_ena_d = 1'b1;
                if (bus.sec_q == 8'h59) begin
                    min_ena_d = 1'b1;
                    if (bus.min_q == 8'h59) begin
                        if (bus.hr_q == HR_MAX) hr_clr_d = 1'b1;
                        else                    hr_ena_d = 1'b1;
                    end
                end
            end
        end else begin
            // Priority: mode edge, then timeout, then the inc action.
            if (mode_edge) begin
                case (state_q)
                    SET_HR:  state_d = SET_MIN;
                    SET_MIN: state_d = SET_SEC;
                    default: state_d = RUN;
                endcase
            end else if (to_q == TO_MAX) begin
                state_d = RUN;
            end else if (inc_act) begin
                case (state_q)
                    SET_HR: begin
                        if (bus.hr_q == HR_MAX) hr_clr_d = 1'b1;
                        else                    hr_ena_d = 1'b1;
                    end
                    SET_MIN: min_ena_d = 1'b1;
                    default: sec_clr_d = 1'b1;
                endcase
            end

            if (mode_edge || inc_act || state_d != state_q) to_d = '0;
            else if (bus.tick_1hz)                         to_d = to_q + 8'd1;

            // Edits restart the blink cycle so the field shows immediately.
            if (state_d != state_q || inc_act) begin
                fast_d  = '0;
                phase_d = 1'b0;
            end else if (bus.tick_fast) begin
                fast_d = fast_q + 2'd1;
                if (fast_q == 2'd3) phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            mode_d_q  <= 1'b1;
            inc_d_q   <= 1'b1;
            to_q      <= '0;
            fast_q    <= '0;
            phase_q   <= 1'b0;
            sec_ena_q <= 1'b0;
            sec_clr_q <= 1'b0;
            min_ena_q <= 1'b0;
            hr_ena_q  <= 1'b0;
            hr_clr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_d_q  <= bus.mode_btn;
            inc_d_q   <= bus.inc_btn;
            to_q      <= to_d;
            fast_q    <= fast_d;
            phase_q   <= phase_d;
            sec_ena_q <= sec_ena_d;
            sec_clr_q <= sec_clr_d;
            min_ena_q <= min_ena_d;
            hr_ena_q  <= hr_ena_d;
            hr_clr_q  <= hr_clr_d;
        end
    end

    assign bus.sec_ena   = sec_ena_q;
    assign bus.sec_clr   = sec_clr_q;
    assign bus.min_ena   = min_ena_q;
    assign bus.hr_ena    = hr_ena_q;
    assign bus.hr_clr    = hr_clr_q;
    assign bus.field_sel = state_q;
    assign bus.blink     = phase_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl (default build, auto-repeat disabled).
module tb_clock_time_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(.HR_MAX(8'h23), .TIMEOUT_S(30), .HOLD_TICKS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         due;
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc_n  = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] obs;
    assign obs = {bus.sec_ena, bus.sec_clr, bus.min_ena, bus.hr_ena, bus.hr_clr,
                  bus.field_sel, bus.blink};

    always @(posedge clk) cyc_n = cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // {sec_ena,sec_clr,min_ena,hr_ena,hr_clr,field_sel,blink}
    function automatic logic [7:0] ov(input logic se, sc, me, he, hc,
                                      input logic [1:0] fs, input logic bl);
        return {se, sc, me, he, hc, fs, bl};
    endfunction

    function automatic logic [7:0] idle(input logic [1:0] fs);
        return ov(0, 0, 0, 0, 0, fs, 0);
    endfunction

    always @(negedge clk)
        while (sb.size() > 0 && sb[0].due <= cyc_n) begin
            e = sb.pop_front();
            check(e.tag, {24'd0, obs}, {24'd0, e.v});
        end

    task automatic cyc(input string tag, input logic t1, tf, md, inc, input logic [7:0] ev);
        bus.tick_1hz  = t1;
        bus.tick_fast = tf;
        bus.mode_btn  = md;
        bus.inc_btn   = inc;
        sb.push_back('{due: cyc_n + 1, v: ev, tag: tag});
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [7:0] s, m, h);
        bus.sec_q = s;
        bus.min_q = m;
        bus.hr_q  = h;
    endtask

    initial begin
        reset = 1'b1;
        set_time(8'h00, 8'h00, 8'h00);
        // Reset with mode held; release reset and keep holding: no edge.
        cyc("rst0", 0, 0, 1, 0, idle(0));
        cyc("rst1", 0, 0, 1, 0, idle(0));
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cyc("mode_held", 0, 0, 1, 0, idle(0));
        cyc("mode_rel", 0, 0, 0, 0, idle(0));

        // RUN cascade
        set_time(8'h59, 8'h59, 8'h23);
        cyc("roll_hrclr", 1, 0, 0, 0, ov(1, 0, 1, 0, 1, 0, 0));
        cyc("roll_width", 0, 0, 0, 0, idle(0));
        set_time(8'h59, 8'h12, 8'h05);
        cyc("roll_min", 1, 0, 0, 0, ov(1, 0, 1, 0, 0, 0, 0));
        set_time(8'h59, 8'h59, 8'h05);
        cyc("roll_hrena", 1, 0, 0, 0, ov(1, 0, 1, 1, 0, 0, 0));
        set_time(8'h30, 8'h59, 8'h23);
        cyc("sec_only", 1, 0, 0, 0, ov(1, 0, 0, 0, 0, 0, 0));
        cyc("run_inc_ign", 0, 0, 0, 1, idle(0));
        cyc("idle", 0, 0, 0, 0, idle(0));

        // Set-mode walk with ticks pulsing
        set_time(8'h59, 8'h59, 8'h22);
        cyc("to_sethr", 0, 0, 1, 0, idle(1));
        cyc("hr_paused", 1, 0, 0, 0, idle(1));
        bus.hr_q = 8'h23;
        cyc("hr_inc_max", 0, 0, 0, 1, ov(0, 0, 0, 0, 1, 1, 0));
        cyc("hr_rel", 0, 0, 0, 0, idle(1));
        bus.hr_q = 8'h22;
        cyc("hr_inc_tick", 1, 0, 0, 1, ov(0, 0, 0, 1, 0, 1, 0));
        cyc("hr_rel2", 0, 0, 0, 0, idle(1));
        cyc("to_setmin", 0, 0, 1, 0, idle(2));
        cyc("min_paused", 1, 0, 0, 0, idle(2));
        cyc("min_inc", 0, 0, 0, 1, ov(0, 0, 1, 0, 0, 2, 0));
        cyc("min_rel", 0, 0, 0, 0, idle(2));
        cyc("mode_wins", 0, 0, 1, 1, idle(3));
        cyc("sec_paused", 1, 0, 0, 0, idle(3));
        cyc("sec_inc", 0, 0, 0, 1, ov(0, 1, 0, 0, 0, 3, 0));
        cyc("sec_rel", 1, 0, 0, 0, idle(3));
        cyc("exit_tick", 1, 0, 1, 0, idle(0));
        bus.sec_q = 8'h30;
        cyc("first_tick", 1, 0, 0, 0, ov(1, 0, 0, 0, 0, 0, 0));
        cyc("idle2", 0, 0, 0, 0, idle(0));

        // Timeout from SET_MIN
        cyc("m1", 0, 0, 1, 0, idle(1));
        cyc("m1r", 0, 0, 0, 0, idle(1));
        cyc("m2", 0, 0, 1, 0, idle(2));
        cyc("m2r", 0, 0, 0, 0, idle(2));
        for (int k = 1; k <= 30; k++) begin
            cyc("to_tick", 1, 0, 0, 0, idle(2));
            if (k < 30) cyc("to_idle", 0, 0, 0, 0, idle(2));
            else        cyc("to_expire", 0, 0, 0, 0, idle(0));
        end
        cyc("to_next_tick", 1, 0, 0, 0, ov(1, 0, 0, 0, 0, 0, 0));

        // Blink phase in SET_HR
        bus.hr_q = 8'h10;
        cyc("b_enter", 0, 0, 1, 0, idle(1));
        cyc("b_rel", 0, 0, 0, 0, idle(1));
        for (int i = 0; i < 3; i++) cyc("b_f123", 0, 1, 0, 0, idle(1));
        cyc("b_f4", 0, 1, 0, 0, ov(0, 0, 0, 0, 0, 1, 1));
        cyc("b_hold", 0, 0, 0, 0, ov(0, 0, 0, 0, 0, 1, 1));
        cyc("b_inc", 0, 0, 0, 1, ov(0, 0, 0, 1, 0, 1, 0));
        cyc("b_incr", 0, 0, 0, 0, idle(1));
        for (int i = 0; i < 3; i++) cyc("b_g123", 0, 1, 0, 0, idle(1));
        cyc("b_g4", 0, 1, 0, 0, ov(0, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++) cyc("b_h123", 0, 1, 0, 0, ov(0, 0, 0, 0, 0, 1, 1));
        cyc("b_h4", 0, 1, 0, 0, idle(1));
        for (int i = 0; i < 3; i++) cyc("b_k123", 0, 1, 0, 0, idle(1));
        cyc("b_k4", 0, 1, 0, 0, ov(0, 0, 0, 0, 0, 1, 1));
        cyc("b_chg", 0, 0, 1, 0, idle(2));
        cyc("b_chgr", 0, 0, 0, 0, idle(2));
        cyc("b_chg2", 0, 0, 1, 0, idle(3));
        cyc("b_chg2r", 0, 0, 0, 0, idle(3));
        cyc("b_run", 0, 0, 1, 0, idle(0));
        cyc("b_runr", 0, 0, 0, 0, idle(0));
        for (int i = 0; i < 4; i++) cyc("b_run_fast", 0, 1, 0, 0, idle(0));

        // Reset mid-operation suppresses the pending strobe
        set_time(8'h59, 8'h59, 8'h05);
        cyc("r_sethr", 0, 0, 1, 0, idle(1));
        bus.mode_btn = 1'b0;
        reset = 1'b1;
        cyc("r_mid", 1, 0, 0, 0, idle(0));
        cyc("r_run_tick_rst", 1, 0, 0, 0, idle(0));
        reset = 1'b0;
        bus.sec_q = 8'h30;
        cyc("r_after", 1, 0, 0, 0, ov(1, 0, 0, 0, 0, 0, 0));
        cyc("r_idle", 0, 0, 0, 0, idle(0));

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
